wb_stage: RTL and testbench

//   MEM/WB pipeline register plus writeback result selection for the RV32I core.

---
 rtl/wb_stage_if.sv | 47 ++++
 rtl/wb_stage.sv | 139 +++++++++++++
 tb/tb_wb_stage.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/wb_stage_if.sv
// MEM/WB bundle: memory-stage inputs, pipeline control, and writeback/forward outputs.
interface wb_stage_if #(
   parameter int unsigned XLEN       = 32,
   parameter int unsigned REG_ADDR_W = 5
);
   // pipeline control
   logic                  stall;
   logic                  flush;

   // memory-stage bundle
   logic                  in_valid;
   logic                  in_reg_write;
   logic [1:0]            in_result_src;
   logic [2:0]            in_funct3;
   logic [REG_ADDR_W-1:0] in_rd;
   logic [XLEN-1:0]       in_alu_result;
   logic [XLEN-1:0]       in_read_data;
   logic [XLEN-1:0]       in_pc_plus4;
   logic [XLEN-1:0]       in_imm;

   // register-file write port
   logic [REG_ADDR_W-1:0] A3;
   logic [XLEN-1:0]       WD3;
   logic                  WE3;

   // forwarding tap and load fault
   logic                  fwd_valid;
   logic [REG_ADDR_W-1:0] fwd_rd;
   logic [XLEN-1:0]       fwd_data;
   logic                  misalign_err;

   // memory stage / pipeline control side
   modport master (
      output stall, flush,
      output in_valid, in_reg_write, in_result_src, in_funct3, in_rd,
      output in_alu_result, in_read_data, in_pc_plus4, in_imm,
      input  A3, WD3, WE3, fwd_valid, fwd_rd, fwd_data, misalign_err
   );

   // writeback stage side
   modport slave (
      input  stall, flush,
      input  in_valid, in_reg_write, in_result_src, in_funct3, in_rd,
      input  in_alu_result, in_read_data, in_pc_plus4, in_imm,
      output A3, WD3, WE3, fwd_valid, fwd_rd, fwd_data, misalign_err
   );
endinterface

// File: rtl/wb_stage.sv
// MEM/WB pipeline register with load alignment/extension and writeback select.
module wb_stage #(
   parameter int unsigned XLEN       = 32,
   parameter int unsigned REG_ADDR_W = 5
) (
   input  logic       clk,
   input  logic       rst,
   wb_stage_if.slave  bus
);

   localparam int unsigned BYTE_W = 8;
   localparam int unsigned HALF_W = 16;

   localparam logic [1:0] SRC_ALU  = 2'b00;
   localparam logic [1:0] SRC_LOAD = 2'b01;
   localparam logic [1:0] SRC_PC4  = 2'b10;
   localparam logic [1:0] SRC_IMM  = 2'b11;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   // registered stage fields
   logic                  valid_q;
   logic                  reg_write_q;
   logic [1:0]            result_src_q;
   logic [2:0]            funct3_q;
   logic [REG_ADDR_W-1:0] rd_q;
   logic [XLEN-1:0]       alu_result_q;
   logic [XLEN-1:0]       read_data_q;
   logic [XLEN-1:0]       pc_plus4_q;
   logic [XLEN-1:0]       imm_q;

   // combinational datapath
   logic [1:0]            addr_c;
   logic [BYTE_W-1:0]     ld_byte_c;
   logic [HALF_W-1:0]     ld_half_c;
   logic [XLEN-1:0]       ld_data_c;
   logic                  is_load_c;
   logic                  misalign_c;
   logic [XLEN-1:0]       wd_c;
   logic                  we_c;

   // Pipeline register: flush beats stall; flush only kills valid, payload is don't-care.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_q      <= 1'b0;
         reg_write_q  <= 1'b0;
         result_src_q <= 2'b00;
         funct3_q     <= 3'b000;
         rd_q         <= '0;
         alu_result_q <= '0;
         read_data_q  <= '0;
         pc_plus4_q   <= '0;
         imm_q        <= '0;
      end else if (bus.flush) begin
         valid_q      <= 1'b0;
      end else if (!bus.stall) begin
         valid_q      <= bus.in_valid;
         reg_write_q  <= bus.in_reg_write;
         result_src_q <= bus.in_result_src;
         funct3_q     <= bus.in_funct3;
         rd_q         <= bus.in_rd;
         alu_result_q <= bus.in_alu_result;
         read_data_q  <= bus.in_read_data;
         pc_plus4_q   <= bus.in_pc_plus4;
         imm_q        <= bus.in_imm;
      end
   end

   // Pick the addressed byte and halfword out of the aligned memory word.
   always_comb begin
      addr_c    = alu_result_q[1:0];
      ld_byte_c = read_data_q[BYTE_W-1:0];
      ld_half_c = read_data_q[HALF_W-1:0];
      case (addr_c)
         2'd0:    ld_byte_c = read_data_q[0*BYTE_W +: BYTE_W];
         2'd1:    ld_byte_c = read_data_q[1*BYTE_W +: BYTE_W];
         2'd2:    ld_byte_c = read_data_q[2*BYTE_W +: BYTE_W];
         default: ld_byte_c = read_data_q[3*BYTE_W +: BYTE_W];
      endcase
      if (addr_c[1]) begin
         ld_half_c = read_data_q[HALF_W +: HALF_W];
      end
   end

   // Sign/zero extension by load type; reserved funct3 codes fall back to the full word.
   always_comb begin
      ld_data_c = read_data_q;
      case (funct3_q)
         F3_LB:   ld_data_c = {{(XLEN-BYTE_W){ld_byte_c[BYTE_W-1]}}, ld_byte_c};
         F3_LH:   ld_data_c = {{(XLEN-HALF_W){ld_half_c[HALF_W-1]}}, ld_half_c};
         F3_LW:   ld_data_c = read_data_q;
         F3_LBU:  ld_data_c = {{(XLEN-BYTE_W){1'b0}}, ld_byte_c};
         F3_LHU:  ld_data_c = {{(XLEN-HALF_W){1'b0}}, ld_half_c};
         default: ld_data_c = read_data_q;
      endcase
   end

   // Misaligned load detection; only halfword and word loads can be misaligned.
   always_comb begin
      is_load_c  = valid_q && (result_src_q == SRC_LOAD);
      misalign_c = 1'b0;
      if (is_load_c) begin
         case (funct3_q)
            F3_LH, F3_LHU: misalign_c = addr_c[0];
            F3_LW:         misalign_c = (addr_c != 2'd0);
            default:       misalign_c = 1'b0;
         endcase
      end
   end

   // Writeback value select and write enable; x0 and faulted loads never write.
   always_comb begin
      wd_c = alu_result_q;
      case (result_src_q)
         SRC_ALU:  wd_c = alu_result_q;
         SRC_LOAD: wd_c = ld_data_c;
         SRC_PC4:  wd_c = pc_plus4_q;
         SRC_IMM:  wd_c = imm_q;
         default:  wd_c = alu_result_q;
      endcase
      we_c = valid_q && reg_write_q && (rd_q != '0) && !misalign_c;
   end

   // Register-file port and forwarding tap are the same view of the stage.
   always_comb begin
      bus.A3           = rd_q;
      bus.WD3          = wd_c;
      bus.WE3          = we_c;
      bus.fwd_valid    = we_c;
      bus.fwd_rd       = rd_q;
      bus.fwd_data     = wd_c;
      bus.misalign_err = misalign_c;
   end

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: spec-level model plus directed literal checks.
module tb_wb_stage;

   localparam int unsigned XLEN       = 32;
   localparam int unsigned REG_ADDR_W = 5;

   logic clk;
   logic rst;

   int n_cmp;
   int n_bad;

   wb_stage_if #(.XLEN(XLEN), .REG_ADDR_W(REG_ADDR_W)) bus ();

   wb_stage #(.XLEN(XLEN), .REG_ADDR_W(REG_ADDR_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model of what the stage currently holds.
   typedef struct {
      bit          valid;
      bit          rw;
      int unsigned src;
      int unsigned f3;
      int unsigned rd;
      longint      alu;
      longint      rdata;
      longint      pc4;
      longint      imm;
   } bundle_t;

   bundle_t m;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, got, exp, $time);
      end
   endtask

   function automatic bit model_misalign(input bundle_t b);
      int unsigned a;
      a = int'(b.alu % 4);
      if (!b.valid || b.src != 1) return 1'b0;
      if (b.f3 == 1 || b.f3 == 5) return (a % 2) != 0;
      if (b.f3 == 2) return a != 0;
      return 1'b0;
   endfunction

   function automatic logic [31:0] model_load(input bundle_t b);
      int unsigned a;
      longint      v;
      a = int'(b.alu % 4);
      case (b.f3)
         0: begin v = (b.rdata >> (8 * a)) % 256;  if (v > 127)   v = v - 256;   end
         4: v = (b.rdata >> (8 * a)) % 256;
         1: begin v = (b.rdata >> (16 * (a / 2))) % 65536; if (v > 32767) v = v - 65536; end
         5: v = (b.rdata >> (16 * (a / 2))) % 65536;
         default: v = b.rdata;
      endcase
      return 32'(v);
   endfunction

   function automatic logic [31:0] model_wd(input bundle_t b);
      case (b.src)
         0: return 32'(b.alu);
         1: return model_load(b);
         2: return 32'(b.pc4);
         default: return 32'(b.imm);
      endcase
   endfunction

   function automatic bit model_we(input bundle_t b);
      return b.valid && b.rw && (b.rd != 0) && !model_misalign(b);
   endfunction

   // Model capture: reset clears, flush kills the bubble, stall holds.
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m <= '{default: 0};
      end else if (bus.flush) begin
         m.valid <= 1'b0;
      end else if (!bus.stall) begin
         m <= '{valid: bus.in_valid, rw: bus.in_reg_write,
                src: int'(bus.in_result_src), f3: int'(bus.in_funct3), rd: int'(bus.in_rd),
                alu: longint'(bus.in_alu_result), rdata: longint'(bus.in_read_data),
                pc4: longint'(bus.in_pc_plus4), imm: longint'(bus.in_imm)};
      end
   end

   // Per-cycle compare against the model on the falling edge.
   always @(negedge clk) begin
      bit exp_we;
      exp_we = model_we(m);
      chk("we3",       32'(bus.WE3),          32'(exp_we));
      chk("misalign",  32'(bus.misalign_err), 32'(model_misalign(m)));
      chk("fwd_valid", 32'(bus.fwd_valid),    32'(bus.WE3));
      chk("fwd_rd",    32'(bus.fwd_rd),       32'(bus.A3));
      chk("fwd_data",  bus.fwd_data,          bus.WD3);
      if (exp_we) begin
         chk("a3",  32'(bus.A3), 32'(m.rd));
         chk("wd3", bus.WD3,     model_wd(m));
      end
   end

   // Apply one memory-stage bundle and advance to the next falling edge.
   task automatic drive(input bit v, input bit rw, input logic [1:0] src, input logic [2:0] f3,
                        input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] rdata,
                        input logic [31:0] pc4, input logic [31:0] imm);
      bus.in_valid      = v;
      bus.in_reg_write  = rw;
      bus.in_result_src = src;
      bus.in_funct3     = f3;
      bus.in_rd         = rd;
      bus.in_alu_result = alu;
      bus.in_read_data  = rdata;
      bus.in_pc_plus4   = pc4;
      bus.in_imm        = imm;
      @(negedge clk);
   endtask

   localparam logic [31:0] RDATA = 32'h80FF_7F01;

   initial begin
      n_cmp = 0;
      n_bad = 0;
      rst = 1'b0;
      bus.stall = 1'b0;
      bus.flush = 1'b0;
      bus.in_valid = 1'b1; bus.in_reg_write = 1'b1; bus.in_result_src = 2'b00;
      bus.in_funct3 = 3'b010; bus.in_rd = 5'd5; bus.in_alu_result = 32'h0000_1234;
      bus.in_read_data = '0; bus.in_pc_plus4 = '0; bus.in_imm = '0;

      // Reset held with live inputs
      repeat (3) @(negedge clk);
      chk("rst_we3", 32'(bus.WE3), 32'h0);
      chk("rst_wd3", bus.WD3,      32'h0);
      chk("rst_a3",  32'(bus.A3),  32'h0);
      chk("rst_mis", 32'(bus.misalign_err), 32'h0);
      rst = 1'b1;

      // ALU op captured on first edge after release
      drive(1, 1, 2'b00, 3'b000, 5'd5, 32'h0000_1234, 0, 0, 0);
      chk("alu_a3",  32'(bus.A3), 32'd5);
      chk("alu_wd3", bus.WD3,     32'h0000_1234);
      chk("alu_we3", 32'(bus.WE3), 32'h1);
      chk("alu_fwd", 32'(bus.fwd_valid), 32'h1);

      // Loads
      drive(1, 1, 2'b01, 3'b000, 5'd7, 32'h0000_1003, RDATA, 0, 0);
      chk("lb3",  bus.WD3, 32'hFFFF_FF80);
      drive(1, 1, 2'b01, 3'b100, 5'd7, 32'h0000_1001, RDATA, 0, 0);
      chk("lbu1", bus.WD3, 32'h0000_007F);
      drive(1, 1, 2'b01, 3'b001, 5'd7, 32'h0000_1002, RDATA, 0, 0);
      chk("lh2",  bus.WD3, 32'hFFFF_80FF);
      drive(1, 1, 2'b01, 3'b101, 5'd7, 32'h0000_1000, RDATA, 0, 0);
      chk("lhu0", bus.WD3, 32'h0000_7F01);
      drive(1, 1, 2'b01, 3'b010, 5'd8, 32'h0000_1000, RDATA, 0, 0);
      chk("lw0",  bus.WD3, RDATA);
      drive(1, 1, 2'b01, 3'b011, 5'd8, 32'h0000_1003, RDATA, 0, 0);
      chk("f3_011", bus.WD3, RDATA);
      drive(1, 1, 2'b01, 3'b000, 5'd8, 32'h0000_1000, RDATA, 0, 0);
      chk("lb0",  bus.WD3, 32'h0000_0001);
      drive(1, 1, 2'b01, 3'b100, 5'd8, 32'h0000_1003, RDATA, 0, 0);
      chk("lbu3", bus.WD3, 32'h0000_0080);

      // Misaligned
      drive(1, 1, 2'b01, 3'b010, 5'd9, 32'h0000_1002, RDATA, 0, 0);
      chk("lw2_mis", 32'(bus.misalign_err), 32'h1);
      chk("lw2_we",  32'(bus.WE3),          32'h0);
      drive(1, 1, 2'b01, 3'b001, 5'd9, 32'h0000_1001, RDATA, 0, 0);
      chk("lh1_mis", 32'(bus.misalign_err), 32'h1);
      chk("lh1_we",  32'(bus.WE3),          32'h0);
      drive(0, 1, 2'b01, 3'b010, 5'd9, 32'h0000_1001, RDATA, 0, 0);
      chk("inv_mis", 32'(bus.misalign_err), 32'h0);

      // x0, JAL, LUI
      drive(1, 1, 2'b00, 3'b000, 5'd0, 32'h0000_00AA, 0, 0, 0);
      chk("x0_we", 32'(bus.WE3), 32'h0);
      drive(1, 1, 2'b10, 3'b000, 5'd1, 32'h0000_0DEAD, 0, 32'h0000_0104, 0);
      chk("jal_wd", bus.WD3, 32'h0000_0104);
      chk("jal_we", 32'(bus.WE3), 32'h1);
      drive(1, 0, 2'b00, 3'b000, 5'd2, 32'h0000_0011, 0, 0, 0);
      chk("norw_we", 32'(bus.WE3), 32'h0);
      drive(1, 1, 2'b11, 3'b000, 5'd3, 32'h0000_0011, 0, 0, 32'hABCD_E000);
      chk("lui_wd", bus.WD3, 32'hABCD_E000);

      // Stall three cycles with changing inputs
      bus.stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive(1, 1, 2'b00, 3'b000, 5'(10 + i), 32'(i + 100), 0, 0, 0);
         chk("stall_wd", bus.WD3, 32'hABCD_E000);
         chk("stall_a3", 32'(bus.A3), 32'd3);
         chk("stall_we", 32'(bus.WE3), 32'h1);
      end
      // Flush during stall
      bus.flush = 1'b1;
      drive(1, 1, 2'b00, 3'b000, 5'd11, 32'h77, 0, 0, 0);
      chk("flst_we", 32'(bus.WE3), 32'h0);
      bus.flush = 1'b0;
      bus.stall = 1'b0;
      drive(1, 1, 2'b00, 3'b000, 5'd4, 32'h55, 0, 0, 0);
      chk("resume_wd", bus.WD3, 32'h0000_0055);
      // Flush alone: one-cycle bubble
      bus.flush = 1'b1;
      drive(1, 1, 2'b00, 3'b000, 5'd6, 32'h66, 0, 0, 0);
      chk("flush_we", 32'(bus.WE3), 32'h0);
      bus.flush = 1'b0;
      drive(1, 1, 2'b00, 3'b000, 5'd6, 32'h66, 0, 0, 0);
      chk("post_flush_we", 32'(bus.WE3), 32'h1);
      chk("post_flush_wd", bus.WD3, 32'h0000_0066);

      // Reset mid-operation drops the live write immediately
      #2 rst = 1'b0;
      #1;
      chk("arst_we", 32'(bus.WE3), 32'h0);
      chk("arst_wd", bus.WD3,      32'h0);
      @(posedge clk); #1;
      chk("arst_edge_we", 32'(bus.WE3), 32'h0);
      @(negedge clk);
      rst = 1'b1;
      drive(1, 1, 2'b00, 3'b000, 5'd12, 32'h0000_0C0C, 0, 0, 0);
      chk("post_rst_wd", bus.WD3, 32'h0000_0C0C);
      chk("post_rst_we", 32'(bus.WE3), 32'h1);

      repeat (2) @(negedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
